// File: rtl/otg_bus_bridge.sv
// Bridges NUM_CH Avalon-MM slave channels onto the shared asynchronous bus of the USB OTG chip.
// Round-robin grant, programmable setup/strobe/hold timing, stretched chip reset and IRQ synchronisers.
module otg_bus_bridge #(
    parameter int NUM_CH         = 2,
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 1,
    parameter int SETUP_CYC      = 1,
    parameter int STROBE_CYC     = 3,
    parameter int HOLD_CYC       = 1,
    parameter int RST_HOLD_CYC   = 16,
    parameter bit INT_ACTIVE_LOW = 1'b1,
    localparam int CH_W          = $clog2(NUM_CH)
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic [NUM_CH-1:0]        avs_chipselect,
    input  logic [NUM_CH-1:0]        avs_read,
    input  logic [NUM_CH-1:0]        avs_write,
    input  logic [NUM_CH*ADDR_W-1:0] avs_address,
    input  logic [NUM_CH*DATA_W-1:0] avs_writedata,
    output logic [NUM_CH*DATA_W-1:0] avs_readdata,
    output logic [NUM_CH-1:0]        avs_waitrequest,
    output logic [NUM_CH-1:0]        avs_irq,
    output logic [CH_W+ADDR_W-1:0]   OTG_ADDR,
    output logic                     OTG_CS_N,
    output logic                     OTG_RD_N,
    output logic                     OTG_WR_N,
    output logic                     OTG_RST_N,
    output logic [DATA_W-1:0]        OTG_DATA_OUT,
    output logic                     OTG_DATA_OE,
    input  logic [DATA_W-1:0]        OTG_DATA_IN,
    input  logic [NUM_CH-1:0]        OTG_INT
);

    localparam int PH_MAX = (SETUP_CYC > STROBE_CYC)
                          ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                          : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int PH_W = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int RC_W = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [PH_W-1:0]            ph_q, ph_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic [CH_W-1:0]            last_q, last_d;
    logic                       wr_q, wr_d;
    logic [CH_W+ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]          dout_q, dout_d;
    logic                       cs_n_q, cs_n_d;
    logic                       rd_n_q, rd_n_d;
    logic                       wr_n_q, wr_n_d;
    logic                       oe_q, oe_d;
    logic [NUM_CH*DATA_W-1:0]   rdata_q, rdata_d;
    logic                       rst_n_q, rst_n_d;
    logic [RC_W-1:0]            rc_q, rc_d;
    logic [NUM_CH-1:0]          int_s1_q, int_s2_q;

    logic [NUM_CH-1:0]          req;
    logic [NUM_CH-1:0]          done;
    logic                       grant_vld;
    logic [CH_W-1:0]            grant_ch;

    assign req = avs_chipselect & (avs_read | avs_write);

    // Round-robin: first requester strictly after the last granted channel.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_vld && req[(int'(last_q) + 1 + i) % NUM_CH]) begin
                grant_vld = 1'b1;
                grant_ch  = CH_W'((int'(last_q) + 1 + i) % NUM_CH);
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        ph_d    = ph_q;
        ch_d    = ch_q;
        last_d  = last_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        rst_n_d = rst_n_q;
        rc_d    = rc_q;

        if (!rst_n_q) begin
            if (rc_q == RC_W'(RST_HOLD_CYC - 1)) rst_n_d = 1'b1;
            else                                 rc_d    = rc_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (grant_vld && rst_n_q) begin
                    ch_d    = grant_ch;
                    wr_d    = avs_write[grant_ch];
                    addr_d  = {grant_ch, avs_address[grant_ch*ADDR_W +: ADDR_W]};
                    if (avs_write[grant_ch]) dout_d = avs_writedata[grant_ch*DATA_W +: DATA_W];
                    ph_d    = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (ph_q == PH_W'(SETUP_CYC - 1)) begin
                    ph_d    = '0;
                    state_d = S_STROBE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_STROBE: begin
                if (ph_q == PH_W'(STROBE_CYC - 1)) begin
                    if (!wr_q) rdata_d[ch_q*DATA_W +: DATA_W] = OTG_DATA_IN;
                    ph_d    = '0;
                    state_d = S_HOLD;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (ph_q == PH_W'(HOLD_CYC - 1)) begin
                    ph_d    = '0;
                    state_d = S_DONE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_DONE: begin
                last_d  = ch_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Pad controls are decoded from the next state so they leave a flop cleanly.
        cs_n_d = !(state_d == S_SETUP || state_d == S_STROBE || state_d == S_HOLD);
        oe_d   = !cs_n_d && wr_d;
        rd_n_d = !(state_d == S_STROBE && !wr_d);
        wr_n_d = !(state_d == S_STROBE && wr_d);
    end

    always_ff @(posedge iCLK) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (iRST) begin
            state_q  <= S_IDLE;
            ph_q     <= '0;
            ch_q     <= '0;
            last_q   <= CH_W'(NUM_CH - 1);
            wr_q     <= 1'b0;
            addr_q   <= '0;
            dout_q   <= '0;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            oe_q     <= 1'b0;
            // NOTE: read-data slices are visible outputs with a defined reset value, so they are reset.
            rdata_q  <= '0;
            rst_n_q  <= 1'b0;
            rc_q     <= '0;
            int_s1_q <= {NUM_CH{INT_ACTIVE_LOW}};
            int_s2_q <= {NUM_CH{INT_ACTIVE_LOW}};
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            ch_q     <= ch_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            oe_q     <= oe_d;
            rdata_q  <= rdata_d;
            rst_n_q  <= rst_n_d;
            rc_q     <= rc_d;
            int_s1_q <= OTG_INT;
            int_s2_q <= int_s1_q;
        end
    end

    always_comb begin
        done = '0;
        if (state_q == S_DONE) done[ch_q] = 1'b1;
    end

    assign avs_waitrequest = req & ~done;
    assign avs_readdata    = rdata_q;
    assign avs_irq         = INT_ACTIVE_LOW ? ~int_s2_q : int_s2_q;

    assign OTG_ADDR     = addr_q;
    assign OTG_CS_N     = cs_n_q;
    assign OTG_RD_N     = rd_n_q;
    assign OTG_WR_N     = wr_n_q;
    assign OTG_RST_N    = rst_n_q;
    assign OTG_DATA_OUT = dout_q;
    assign OTG_DATA_OE  = oe_q;

endmodule

// File: tb/tb_otg_bus_bridge.sv
// Scoreboard bench for otg_bus_bridge at default parameters: drivers push expectations,
// a negedge monitor pops and compares on every Avalon completion.
module tb_otg_bus_bridge;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 1;

    typedef struct {
        logic        wr;
        logic [1:0]  bus_addr;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              tb_cs [NUM_CH];
    logic              tb_rd [NUM_CH];
    logic              tb_wr [NUM_CH];
    logic [ADDR_W-1:0] tb_addr [NUM_CH];
    logic [DATA_W-1:0] tb_wdata [NUM_CH];
    logic [NUM_CH-1:0] otg_int;

    logic [NUM_CH-1:0]        avs_chipselect, avs_read, avs_write;
    logic [NUM_CH*ADDR_W-1:0] avs_address;
    logic [NUM_CH*DATA_W-1:0] avs_writedata, avs_readdata;
    logic [NUM_CH-1:0]        avs_waitrequest, avs_irq;
    logic [1:0]               otg_addr;
    logic                     otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n, otg_oe;
    logic [DATA_W-1:0]        otg_dout, otg_din;

    assign avs_chipselect = {tb_cs[1], tb_cs[0]};
    assign avs_read       = {tb_rd[1], tb_rd[0]};
    assign avs_write      = {tb_wr[1], tb_wr[0]};
    assign avs_address    = {tb_addr[1], tb_addr[0]};
    assign avs_writedata  = {tb_wdata[1], tb_wdata[0]};

    // Chip model: fixed register contents driven only while RD_N is low.
    function automatic logic [15:0] chip_rd(input logic [1:0] a);
        case (a)
            2'b00:   return 16'h1234;
            2'b01:   return 16'h0BEE;
            2'b10:   return 16'hC0DE;
            default: return 16'h7E57;
        endcase
    endfunction
    assign otg_din = otg_rd_n ? 16'hDEAD : chip_rd(otg_addr);

    otg_bus_bridge dut (
        .iCLK            (clk),
        .iRST            (rst),
        .avs_chipselect  (avs_chipselect),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_address     (avs_address),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .avs_irq         (avs_irq),
        .OTG_ADDR        (otg_addr),
        .OTG_CS_N        (otg_cs_n),
        .OTG_RD_N        (otg_rd_n),
        .OTG_WR_N        (otg_wr_n),
        .OTG_RST_N       (otg_rst_n),
        .OTG_DATA_OUT    (otg_dout),
        .OTG_DATA_OE     (otg_oe),
        .OTG_DATA_IN     (otg_din),
        .OTG_INT         (otg_int)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   grant_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Avalon master for one channel; data is the write data or the hand-computed read result.
    task automatic avs_xfer(input int ch, input bit wr, input logic [0:0] addr,
                            input logic [15:0] data, output int lat);
        exp_t e;
        e.wr       = wr;
        e.bus_addr = {ch[0], addr};
        e.data     = data;
        if (ch == 0) exp_q0.push_back(e);
        else         exp_q1.push_back(e);
        tb_cs[ch]    = 1'b1;
        tb_rd[ch]    = !wr;
        tb_wr[ch]    = wr;
        tb_addr[ch]  = addr;
        tb_wdata[ch] = wr ? data : 16'h0000;
        lat = -1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (!avs_waitrequest[ch]) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: ch%0d waitrequest still high after 80 cycles", ch);
        end
        @(posedge clk); #1;
        tb_cs[ch] = 1'b0;
        tb_rd[ch] = 1'b0;
        tb_wr[ch] = 1'b0;
    endtask

    // Monitor: snoops the pad bus and scores every Avalon completion.
    initial begin
        exp_t       e;
        logic [1:0]  cap_addr;
        logic [15:0] cap_data;
        logic        cap_oe, cap_wr_seen, cap_rd_seen;
        cap_addr = '0; cap_data = '0; cap_oe = 1'b0;
        cap_wr_seen = 1'b0; cap_rd_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!otg_wr_n) begin
                cap_wr_seen = 1'b1; cap_addr = otg_addr; cap_data = otg_dout; cap_oe = otg_oe;
            end
            if (!otg_rd_n) begin
                cap_rd_seen = 1'b1; cap_addr = otg_addr;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (!rst && tb_cs[c] && (tb_rd[c] || tb_wr[c]) && !avs_waitrequest[c]) begin
                    grant_log.push_back(c);
                    if ((c == 0 && exp_q0.size() == 0) || (c == 1 && exp_q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: ch%0d completed with nothing expected", c);
                    end else begin
                        e = (c == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        if (e.wr) begin
                            check("sb_wr_strobe", 32'(cap_wr_seen), 32'd1);
                            check("sb_wr_addr", 32'(cap_addr), 32'(e.bus_addr));
                            check("sb_wr_data", 32'(cap_data), 32'(e.data));
                            check("sb_wr_oe", 32'(cap_oe), 32'd1);
                        end else begin
                            check("sb_rd_strobe", 32'(cap_rd_seen), 32'd1);
                            check("sb_rd_addr", 32'(cap_addr), 32'(e.bus_addr));
                            check("sb_rd_data", 32'(avs_readdata[c*16 +: 16]), 32'(e.data));
                        end
                    end
                    cap_wr_seen = 1'b0;
                    cap_rd_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat1, lat2, lat3, lat5, lat_x;
        int l0a, l0b, l0c, l1a, l1b, l1c;
        for (int c = 0; c < NUM_CH; c++) begin
            tb_cs[c] = 1'b0; tb_rd[c] = 1'b0; tb_wr[c] = 1'b0;
            tb_addr[c] = '0; tb_wdata[c] = '0;
        end
        otg_int = 2'b11;
        rst     = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", 32'(otg_cs_n), 32'd1);
        check("rst_rd_n", 32'(otg_rd_n), 32'd1);
        check("rst_wr_n", 32'(otg_wr_n), 32'd1);
        check("rst_rst_n", 32'(otg_rst_n), 32'd0);
        check("rst_oe", 32'(otg_oe), 32'd0);
        check("rst_dout", 32'(otg_dout), 32'd0);
        check("rst_addr", 32'(otg_addr), 32'd0);
        check("rst_rdata", avs_readdata, 32'd0);
        check("rst_irq", 32'(avs_irq), 32'd0);
        check("rst_waitreq", 32'(avs_waitrequest), 32'd0);

        // Test 1: reset stretch; ch0 read issued at release waits for OTG_RST_N.
        @(posedge clk); #1;
        rst = 1'b0;
        fork
            avs_xfer(0, 1'b0, 1'b1, 16'h0BEE, lat1);
            for (int k = 0; k <= 16; k++) begin
                @(negedge clk);
                check("t1_rst_n", 32'(otg_rst_n), (k >= 16) ? 32'd1 : 32'd0);
            end
        join
        check("t1_latency", lat1, 32'd22);

        // Test 2: single ch1 write, cycle-accurate strobe shape.
        fork
            avs_xfer(1, 1'b1, 1'b1, 16'hA55A, lat2);
            for (int k = 0; k <= 6; k++) begin
                @(negedge clk);
                check("t2_cs_n", 32'(otg_cs_n), (k >= 1 && k <= 5) ? 32'd0 : 32'd1);
                check("t2_wr_n", 32'(otg_wr_n), (k >= 2 && k <= 4) ? 32'd0 : 32'd1);
                check("t2_oe", 32'(otg_oe), (k >= 1 && k <= 5) ? 32'd1 : 32'd0);
                check("t2_rd_n", 32'(otg_rd_n), 32'd1);
                check("t2_waitreq", 32'(avs_waitrequest[1]), (k == 6) ? 32'd0 : 32'd1);
                if (k >= 1 && k <= 5) begin
                    check("t2_addr", 32'(otg_addr), 32'd3);
                    check("t2_dout", 32'(otg_dout), 32'hA55A);
                end
            end
        join
        check("t2_latency", lat2, 32'd6);

        // Test 3: ch0 read, then ch1 traffic must not disturb slice 0.
        avs_xfer(0, 1'b0, 1'b0, 16'h1234, lat3);
        check("t3_latency", lat3, 32'd6);
        avs_xfer(1, 1'b0, 1'b0, 16'hC0DE, lat_x);
        avs_xfer(1, 1'b1, 1'b0, 16'h5A5A, lat_x);
        @(negedge clk);
        check("t3_slice0_held", 32'(avs_readdata[15:0]), 32'h1234);
        check("t3_slice1", 32'(avs_readdata[31:16]), 32'hC0DE);

        // Test 4: both channels back to back; last grant was ch1 so ch0 leads.
        @(posedge clk); #1;
        grant_log.delete();
        fork
            begin
                avs_xfer(0, 1'b1, 1'b0, 16'h1000, l0a);
                avs_xfer(0, 1'b0, 1'b1, 16'h0BEE, l0b);
                avs_xfer(0, 1'b1, 1'b1, 16'h1002, l0c);
            end
            begin
                avs_xfer(1, 1'b0, 1'b1, 16'h7E57, l1a);
                avs_xfer(1, 1'b1, 1'b0, 16'h2001, l1b);
                avs_xfer(1, 1'b0, 1'b0, 16'hC0DE, l1c);
            end
        join
        check("t4_grant_count", grant_log.size(), 32'd6);
        for (int i = 0; i < grant_log.size() && i < 6; i++)
            check("t4_grant_order", grant_log[i], i % 2);
        check("t4_lat_ch0_0", l0a, 32'd6);
        check("t4_lat_ch0_1", l0b, 32'd13);
        check("t4_lat_ch0_2", l0c, 32'd13);
        check("t4_lat_ch1_0", l1a, 32'd13);
        check("t4_lat_ch1_1", l1b, 32'd13);
        check("t4_lat_ch1_2", l1c, 32'd13);

        // Test 5: reset during STROBE of a ch0 read; it restarts after the stretch.
        @(posedge clk); #1;
        fork
            avs_xfer(0, 1'b0, 1'b0, 16'h1234, lat5);
            begin
                repeat (3) @(posedge clk); #1;
                rst = 1'b1;
                @(negedge clk);
                check("t5_in_strobe", 32'(otg_rd_n), 32'd0);
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check("t5_rd_n", 32'(otg_rd_n), 32'd1);
                check("t5_cs_n", 32'(otg_cs_n), 32'd1);
                check("t5_wr_n", 32'(otg_wr_n), 32'd1);
                check("t5_oe", 32'(otg_oe), 32'd0);
                check("t5_rst_n", 32'(otg_rst_n), 32'd0);
                check("t5_waitreq", 32'(avs_waitrequest[0]), 32'd1);
                check("t5_rdata_cleared", 32'(avs_readdata[15:0]), 32'd0);
            end
        join
        check("t5_latency", lat5, 32'd26);

        // Test 6: interrupt synchronisation, active-low inputs.
        @(posedge clk); #1;
        otg_int = 2'b01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t6_irq1_assert", 32'(avs_irq), (k >= 2) ? 32'd2 : 32'd0);
        end
        @(posedge clk); #1;
        otg_int = 2'b10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_irq_swap", 32'(avs_irq), (k >= 2) ? 32'd1 : 32'd2);
        end
        @(posedge clk); #1;
        otg_int = 2'b11;
        repeat (3) @(negedge clk);
        check("t6_irq_clear", 32'(avs_irq), 32'd0);

        repeat (3) @(posedge clk);
        check("sb_drained_ch0", exp_q0.size(), 32'd0);
        check("sb_drained_ch1", exp_q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
